// File: rtl/ws2812_framebuf.sv
// Double-buffered RGB frame store with global brightness scaling for the ws2812c strip driver.
// The host fills the back bank; a commit swaps banks at the next frame boundary (address 0).
module ws2812_framebuf #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned AW       = $clog2(NUM_LEDS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_rgb,
    input  logic          commit,
    output logic          commit_pending,
    input  logic [7:0]    brightness,
    input  logic [AW-1:0] address,
    input  logic          new_address,
    input  logic          data_request,
    output logic [7:0]    red_out,
    output logic [7:0]    green_out,
    output logic [7:0]    blue_out,
    output logic          rgb_valid,
    output logic          underrun,
    output logic [7:0]    frame_count
);

    typedef enum logic [1:0] {StIdle, StRead, StScale, StHold} state_e;

    state_e        state_q, state_d;
    logic          init_q;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          front_q, front_d;
    logic          front_valid_q, front_valid_d;
    logic          commit_pending_q, commit_pending_d;
    logic [7:0]    bright_q, bright_d;
    logic [7:0]    frame_q, frame_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    red_q, red_d;
    logic [7:0]    green_q, green_d;
    logic [7:0]    blue_q, blue_d;
    logic          rgb_valid_q, rgb_valid_d;

    logic          trigger;
    logic [AW-1:0] trig_addr;
    logic          boundary;
    logic          wr_en;
    logic [AW:0]   wr_idx;
    logic [AW:0]   rd_idx;
    logic [23:0]   ram_rdata_q;
    logic [23:0]   mem_q [2*NUM_LEDS];

    // out = c * (b + 1) >> 8, so b = 255 passes c unchanged and b = 0 gives 0.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * (16'(b) + 16'd1);
        return p[15:8];
    endfunction

    // The first cycle after reset release acts as a trigger for LED 0.
    assign trigger   = new_address | init_q;
    assign trig_addr = new_address ? address : '0;
    assign boundary  = trigger && (trig_addr == '0);

    assign wr_en  = wr_valid && !commit_pending_q;
    assign wr_idx = {~front_q, wr_addr};
    assign rd_idx = {front_q, rd_addr_q};

    // Block RAM: no reset, synchronous read issued in StRead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_rgb;
        end
        if (state_q == StRead) begin
            ram_rdata_q <= mem_q[rd_idx];
        end
    end

    always_comb begin
        front_d          = front_q;
        front_valid_d    = front_valid_q;
        commit_pending_d = commit_pending_q;
        bright_d         = bright_q;
        frame_d          = frame_q;

        if (boundary) begin
            if (commit_pending_q) begin
                front_d       = ~front_q;
                front_valid_d = 1'b1;
            end
            commit_pending_d = 1'b0;
            bright_d         = brightness;
            frame_d          = frame_q + 8'd1;
        end
        // A commit in the boundary cycle itself is held over for the next frame.
        if (commit && !commit_pending_q) begin
            commit_pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        underrun_d = underrun_q | (data_request && (state_q != StHold));

        case (state_q)
            StIdle: begin
            end
            StRead: begin
                state_d = StScale;
            end
            StScale: begin
                state_d = StHold;
                if (front_valid_q) begin
                    red_d   = scale(ram_rdata_q[23:16], bright_q);
                    green_d = scale(ram_rdata_q[15:8], bright_q);
                    blue_d  = scale(ram_rdata_q[7:0], bright_q);
                end else begin
                    red_d   = 8'h00;
                    green_d = 8'h00;
                    blue_d  = 8'h00;
                end
            end
            StHold: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any trigger (re)starts the fetch, including one landing mid-prefetch.
        if (trigger) begin
            state_d   = StRead;
            rd_addr_d = trig_addr;
        end

        rgb_valid_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= StIdle;
            init_q           <= 1'b1;
            rd_addr_q        <= '0;
            front_q          <= 1'b0;
            front_valid_q    <= 1'b0;
            commit_pending_q <= 1'b0;
            bright_q         <= 8'hFF;
            frame_q          <= 8'h00;
            underrun_q       <= 1'b0;
            red_q            <= 8'h00;
            green_q          <= 8'h00;
            blue_q           <= 8'h00;
            rgb_valid_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            init_q           <= 1'b0;
            rd_addr_q        <= rd_addr_d;
            front_q          <= front_d;
            front_valid_q    <= front_valid_d;
            commit_pending_q <= commit_pending_d;
            bright_q         <= bright_d;
            frame_q          <= frame_d;
            underrun_q       <= underrun_d;
            red_q            <= red_d;
            green_q          <= green_d;
            blue_q           <= blue_d;
            rgb_valid_q      <= rgb_valid_d;
        end
    end

    assign wr_ready       = !commit_pending_q;
    assign commit_pending = commit_pending_q;
    assign red_out        = red_q;
    assign green_out      = green_q;
    assign blue_out       = blue_q;
    assign rgb_valid      = rgb_valid_q;
    assign underrun       = underrun_q;
    assign frame_count    = frame_q;

endmodule

// File: tb/tb_ws2812_framebuf.sv
// Directed bench for ws2812_framebuf (NUM_LEDS = 4): reset, commit/swap, brightness,
// write stall, boundary-cycle commit, asynchronous reset and underrun.
module tb_ws2812_framebuf;

    logic        clk;
    logic        resetn;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic        commit;
    logic        commit_pending;
    logic [7:0]  brightness;
    logic [1:0]  address;
    logic        new_address;
    logic        data_request;
    logic [7:0]  red_out;
    logic [7:0]  green_out;
    logic [7:0]  blue_out;
    logic        rgb_valid;
    logic        underrun;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;

    ws2812_framebuf #(.NUM_LEDS(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_rgb        (wr_rgb),
        .commit        (commit),
        .commit_pending(commit_pending),
        .brightness    (brightness),
        .address       (address),
        .new_address   (new_address),
        .data_request  (data_request),
        .red_out       (red_out),
        .green_out     (green_out),
        .blue_out      (blue_out),
        .rgb_valid     (rgb_valid),
        .underrun      (underrun),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_led(input logic [1:0] a, input logic [23:0] rgb);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_rgb   = rgb;
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
    endtask

    task automatic pulse_addr(input logic [1:0] a);
        new_address = 1'b1;
        address     = a;
        tick(1);
        new_address = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_rgb = '0; commit = 1'b0;
        brightness = 8'hFF; address = '0; new_address = 1'b0; data_request = 1'b0;
        tick(2);
        checks++;
        if (rgb_valid !== 1'b0 || frame_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: rgb_valid=%b frame=%h want 0 00", rgb_valid, frame_count);
        end
        checks++;
        if (wr_ready !== 1'b1 || commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr: wr_ready=%b pending=%b want 1 0", wr_ready, commit_pending);
        end
        resetn = 1'b1;
        tick(2);
        checks++;
        if (rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_early: rgb_valid=%b want 0", rgb_valid);
        end
        tick(1);
        checks++;
        if (rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_latency: rgb_valid=%b want 1", rgb_valid);
        end
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_rgb: got %h want 000000", {red_out, green_out, blue_out});
        end
        checks++;
        if (frame_count !== 8'h01 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame: frame=%h underrun=%b want 01 0", frame_count, underrun);
        end
    endtask

    task automatic test_commit();
        logic [23:0] leds [4];
        leds = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        for (int i = 0; i < 4; i++) write_led(2'(i), leds[i]);
        pulse_commit();
        checks++;
        if (commit_pending !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_rise: pending=%b wr_ready=%b want 1 0", commit_pending, wr_ready);
        end
        for (int a = 1; a < 4; a++) begin
            pulse_addr(2'(a));
            tick(2);
            checks++;
            if (commit_pending !== 1'b1 || wr_ready !== 1'b0 ||
                {red_out, green_out, blue_out} !== 24'h000000) begin
                errors++;
                $display("FAIL commit_wait%0d: pending=%b wr_ready=%b rgb=%h want 1 0 000000",
                         a, commit_pending, wr_ready, {red_out, green_out, blue_out});
            end
        end
        pulse_addr(2'd0);
        checks++;
        if (commit_pending !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL commit_fall: pending=%b wr_ready=%b want 0 1", commit_pending, wr_ready);
        end
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h112233 || rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL swap_led0: got %h v=%b want 112233 1",
                     {red_out, green_out, blue_out}, rgb_valid);
        end
        checks++;
        if (frame_count !== 8'h02) begin
            errors++;
            $display("FAIL swap_frame: got %h want 02", frame_count);
        end
        pulse_addr(2'd1);
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h445566) begin
            errors++;
            $display("FAIL swap_led1: got %h want 445566", {red_out, green_out, blue_out});
        end
    endtask

    task automatic test_brightness();
        write_led(2'd0, 24'hFF8001);
        write_led(2'd1, 24'h102030);
        pulse_commit();
        brightness = 8'h7F;
        pulse_addr(2'd0);
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h7F4000) begin
            errors++;
            $display("FAIL bright_7f: got %h want 7F4000", {red_out, green_out, blue_out});
        end
        brightness = 8'h00;
        pulse_addr(2'd1);
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h081018) begin
            errors++;
            $display("FAIL bright_midframe: got %h want 081018", {red_out, green_out, blue_out});
        end
        pulse_addr(2'd0);
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h000000) begin
            errors++;
            $display("FAIL bright_zero: got %h want 000000", {red_out, green_out, blue_out});
        end
        brightness = 8'hFF;
        pulse_addr(2'd0);
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'hFF8001 || frame_count !== 8'h05) begin
            errors++;
            $display("FAIL bright_full: got %h frame=%h want FF8001 05",
                     {red_out, green_out, blue_out}, frame_count);
        end
    endtask

    task automatic test_stall();
        pulse_commit();
        wr_valid = 1'b1;
        wr_addr  = 2'd0;
        wr_rgb   = 24'hABCDEF;
        tick(2);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: wr_ready=%b want 0", wr_ready);
        end
        pulse_addr(2'd0);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: wr_ready=%b want 1", wr_ready);
        end
        tick(1);
        wr_valid = 1'b0;
        tick(1);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h112233 || frame_count !== 8'h06) begin
            errors++;
            $display("FAIL stall_display: got %h frame=%h want 112233 06",
                     {red_out, green_out, blue_out}, frame_count);
        end
        pulse_commit();
        pulse_addr(2'd0);
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'hABCDEF) begin
            errors++;
            $display("FAIL stall_landed: got %h want ABCDEF", {red_out, green_out, blue_out});
        end
    endtask

    task automatic test_back_to_back();
        commit      = 1'b1;
        new_address = 1'b1;
        address     = 2'd0;
        tick(1);
        commit      = 1'b0;
        new_address = 1'b0;
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL boundary_commit_pending: got %b want 1", commit_pending);
        end
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'hABCDEF) begin
            errors++;
            $display("FAIL boundary_commit_noswap: got %h want ABCDEF",
                     {red_out, green_out, blue_out});
        end
        pulse_addr(2'd0);
        tick(2);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h112233 || commit_pending !== 1'b0 ||
            frame_count !== 8'h09) begin
            errors++;
            $display("FAIL boundary_commit_swap: got %h pending=%b frame=%h want 112233 0 09",
                     {red_out, green_out, blue_out}, commit_pending, frame_count);
        end
    endtask

    task automatic test_async_reset();
        pulse_commit();
        pulse_addr(2'd2);
        tick(1);
        checks++;
        if (red_out !== 8'h11 || rgb_valid !== 1'b0 || commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL scale_state: red=%h v=%b pending=%b want 11 0 1",
                     red_out, rgb_valid, commit_pending);
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h000000 || rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rgb: got %h v=%b want 000000 0",
                     {red_out, green_out, blue_out}, rgb_valid);
        end
        checks++;
        if (commit_pending !== 1'b0 || frame_count !== 8'h00 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_state: pending=%b frame=%h wr_ready=%b want 0 00 1",
                     commit_pending, frame_count, wr_ready);
        end
        tick(1);
        resetn = 1'b1;
        tick(3);
        checks++;
        if (rgb_valid !== 1'b1 || {red_out, green_out, blue_out} !== 24'h000000 ||
            frame_count !== 8'h01) begin
            errors++;
            $display("FAIL async_restart: v=%b rgb=%h frame=%h want 1 000000 01",
                     rgb_valid, {red_out, green_out, blue_out}, frame_count);
        end
    endtask

    task automatic test_underrun();
        data_request = 1'b1;
        tick(1);
        data_request = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_hold_ok: got %b want 0", underrun);
        end
        pulse_addr(2'd1);
        data_request = 1'b1;
        tick(1);
        data_request = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: got %b want 1", underrun);
        end
        tick(5);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky: got %b want 1", underrun);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: got %b want 0", underrun);
        end
        tick(1);
        resetn = 1'b1;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_commit();
        test_brightness();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_underrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_framebuf.md
# ws2812_framebuf

- Double-buffered RGB frame store with global brightness scaling that feeds the `ws2812c` strip driver.
- A host-side writer fills the back buffer through a valid/ready port, then requests a commit. At the next frame boundary the back and front buffers swap atomically, so a frame is never torn.
- For each LED the driver announces, the block prefetches that LED's colour, scales it and holds it on `red_out`/`green_out`/`blue_out` well before the driver samples it.

## Interface
Parameters:
- `NUM_LEDS`, default 4: LEDs per frame. Must be a power of two and ≥2, so it matches the driver's address wrap.
- `AW`, default clog2(NUM_LEDS): LED address width.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `wr_valid` in 1: host write strobe.
- `wr_ready` out 1: write accepted when high together with `wr_valid`.
- `wr_addr` in AW: LED index to write.
- `wr_rgb` in 24: {red, green, blue} for that LED.
- `commit` in 1: single-cycle pulse requesting a buffer swap.
- `commit_pending` out 1: a commit is waiting for the next frame boundary.
- `brightness` in 8: global brightness, sampled at each frame boundary.
- `address` in AW: LED index from the driver.
- `new_address` in 1: driver pulse indicating `address` holds the next LED index.
- `data_request` in 1: driver pulse; the driver samples the colour outputs on the following cycle.
- `red_out`, `green_out`, `blue_out` out 8 each: scaled colour of the prefetched LED.
- `rgb_valid` out 1: the colour outputs hold the completed prefetch.
- `underrun` out 1: sticky; set when a `data_request` arrives while `rgb_valid`=0.
- `frame_count` out 8: count of frame boundaries, wraps 255→0.

## Operation
- Storage:
  - Two banks, each NUM_LEDS×24, using synchronous-read block RAM. Contents are not reset.
  - `front` (1 bit) selects the bank being read; the host writes bank `!front`.
  - `front_valid` is cleared by reset and set by the first swap. While `front_valid`=0, the scaled output is forced to 0.
- Write port:
  - `wr_ready` = !commit_pending.
  - A write with `wr_valid`&&`wr_ready` updates `mem[!front][wr_addr]` at that edge.
  - A write and `commit` may occur in the same cycle; the write is kept and the commit is registered.
  - A `commit` while `commit_pending`=1 is ignored.
- Frame boundary: a trigger with `address`==0. A trigger is `new_address` (fetch LED `address`) or the first cycle after reset release (fetch LED 0). At a boundary:
  - If `commit_pending`: `front` toggles, `front_valid`←1, `commit_pending`←0.
  - `bright_q`←`brightness`.
  - `frame_count` increments.
  - The fetch issued in the same cycle reads the post-swap front bank with the new `bright_q`.
- Scaling: out = (c × (bright_q+1)) >> 8. The product is 16 bits; take [15:8].
  - `bright_q`=255 passes c exactly.
  - `bright_q`=0 gives 0.
  - Reset value of `bright_q` is 8'hFF.
- Prefetch FSM:
  - IDLE: wait for a trigger. On trigger, latch the read address and go to READ.
  - READ: issue the RAM read; `rgb_valid`←0; go to SCALE.
  - SCALE: multiply the RAM data, register the three outputs; go to HOLD.
  - HOLD: `rgb_valid`=1; outputs are held stable. A trigger goes to READ.
  - A trigger arriving in READ or SCALE restarts the fetch from READ with the new address.
- `data_request`:
  - Causes no state change.
  - If asserted while the FSM is not in HOLD, `underrun`←1. Only reset clears `underrun`.
- Asynchronous reset (including mid-frame):
  - FSM←IDLE with a pending initial trigger.
  - `front`←0, `front_valid`←0, `commit_pending`←0, `bright_q`←FF, `frame_count`←0, `underrun`←0.
  - All colour outputs←0, `rgb_valid`←0.
  - `wr_ready`=1 after reset.

## Timing
- Trigger registered at edge E:
  - READ during cycle E+1.
  - SCALE during E+2.
  - Outputs and `rgb_valid` valid from E+3, i.e. 3 cycles of latency.
- The driver spaces `new_address` and `data_request` by thousands of cycles, so underrun occurs only on an interface fault.
- Commit: `commit_pending` rises the cycle after `commit`. It falls the cycle after the boundary trigger, and `wr_ready` rises in the same cycle.
- `commit` arriving in the boundary cycle itself waits for the following frame.

## Test plan
- Reset release with no commits, NUM_LEDS=4:
  - `rgb_valid`=1 three cycles after reset release.
  - Outputs 0,0,0.
  - `frame_count`=1.
  - `underrun`=0.
- Write LEDs 0..3 = 24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, then `commit`, then pulse `new_address` for addresses 1,2,3,0,1:
  - `commit_pending` stays 1 until the address-0 trigger, and `wr_ready`=0 while it is pending.
  - After the address-0 trigger, LED0 reads R=11 G=22 B=33.
  - The following address-1 trigger then reads R=44 G=55 B=66.
- `brightness`=8'h7F with LED 24'hFF8001: after the next boundary, outputs are R=7F G=40 B=00.
  - Changing `brightness` mid-frame has no effect until the next boundary.
- `wr_valid` held high during `commit_pending`: no write occurs until the swap. The stalled write then lands in the new back bank and the displayed frame is unaffected.
- `data_request` one cycle after `new_address`: `underrun`=1 and stays 1. After `resetn` is pulsed, `underrun`=0.
- Assert `resetn`=0 mid-prefetch (SCALE state): outputs are 0 and `rgb_valid`=0 immediately, without waiting for a clock edge. `commit_pending`=0 and `frame_count`=0.
